// File: rtl/axil_adc_capture_pkg.sv
// Register map, FIFO entry layout and sequencer states shared by the
// AXI4-Lite ADC capture block.
package axil_adc_capture_pkg;
    localparam int REG_CTRL    = 'h00;
    localparam int REG_DECIM   = 'h04;
    localparam int REG_STATUS  = 'h08;
    localparam int REG_FIFO    = 'h0C;
    localparam int REG_CH_LAST = 'h10;

    localparam int CTRL_MASK_LSB   = 0;
    localparam int CTRL_THRESH_LSB = 16;
    localparam int CTRL_CLEAR_BIT  = 31;
    localparam int STAT_LEVEL_LSB  = 0;
    localparam int STAT_EMPTY_BIT  = 16;
    localparam int STAT_FULL_BIT   = 17;
    localparam int STAT_OVF_BIT    = 18;
    localparam int STAT_OVR_BIT    = 19;
    localparam int FD_CH_LSB       = 24;
    localparam int FD_VALID_BIT    = 31;

    typedef struct packed {
        logic [2:0]  channel;
        logic [15:0] sample;
    } fifo_entry_t;

    typedef enum logic {ST_IDLE, ST_SCAN} seq_state_t;
endpackage

// File: rtl/axil_adc_sample_fifo.sv
// Synchronous sample FIFO; pointers carry one extra wrap bit so that
// level = wr_ptr - rd_ptr distinguishes full from empty.
module axil_adc_sample_fifo
    import axil_adc_capture_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t pop_data,
    output logic [AW:0] level,
    output logic        empty,
    output logic        full
);
    fifo_entry_t mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_push, do_pop;

    assign level    = wr_ptr - rd_ptr;
    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(DEPTH));
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so push-while-full is accepted
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/axil_adc_capture.sv
// AXI4-Lite ADC capture slave: decimated snapshots of NUM_CH channels are
// serialised into a sample FIFO that software drains through FIFO_DATA.
module axil_adc_capture
    import axil_adc_capture_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int ADC_WIDTH  = 14,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [ADDR_WIDTH-1:0]       s_axi_awaddr,
    input  logic [2:0]                  s_axi_awprot,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [31:0]                 s_axi_wdata,
    input  logic [3:0]                  s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]       s_axi_araddr,
    input  logic [2:0]                  s_axi_arprot,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [31:0]                 s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    input  logic [NUM_CH*ADC_WIDTH-1:0] adc_data,
    input  logic                        adc_valid,
    output logic                        irq
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_CH-1:0]                 mask;
    logic [7:0]                        thresh;
    logic [15:0]                       decim_n, decim_cnt;
    logic                              overflow, overrun;
    logic [NUM_CH-1:0][ADC_WIDTH-1:0]  ch_last, snapshot;
    seq_state_t                        state;
    logic [NUM_CH-1:0]                 pend, pend_next;
    logic [2:0]                        scan_ch;
    logic [15:0]                       scan_sample;
    logic                              push, pop_req, pop_fire;
    fifo_entry_t                       push_data, pop_data;
    logic [LVL_W-1:0]                  level;
    logic                              empty, full;
    logic [31:0]                       rd_word;
    logic                              wr_en, rd_en;
    logic                              wr_ctrl, wr_decim, wr_status, soft_clr;
    logic                              unused_ok;

    function automatic logic hit(input logic [ADDR_WIDTH-1:0] a, input int off);
        return {a[ADDR_WIDTH-1:2], 2'b00} == ADDR_WIDTH'(off);
    endfunction

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wdata,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;

    assign wr_en     = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
    assign rd_en     = s_axi_arready && s_axi_arvalid;
    assign wr_ctrl   = wr_en && hit(s_axi_awaddr, REG_CTRL);
    assign wr_decim  = wr_en && hit(s_axi_awaddr, REG_DECIM);
    assign wr_status = wr_en && hit(s_axi_awaddr, REG_STATUS);
    assign soft_clr  = wr_ctrl && s_axi_wstrb[3] && s_axi_wdata[CTRL_CLEAR_BIT];

    // AXI handshakes: ready pulses one cycle after the request is seen idle
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_awready <= !s_axi_awready && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
            s_axi_wready  <= !s_axi_awready && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
            if (wr_en)                             s_axi_bvalid <= 1'b1;
            else if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
            s_axi_arready <= !s_axi_arready && s_axi_arvalid && !s_axi_rvalid;
            if (rd_en) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_word;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mask    <= '0;
            thresh  <= '0;
            decim_n <= '0;
        end else begin
            if (wr_ctrl && s_axi_wstrb[0]) mask    <= s_axi_wdata[CTRL_MASK_LSB +: NUM_CH];
            if (wr_ctrl && s_axi_wstrb[2]) thresh  <= s_axi_wdata[CTRL_THRESH_LSB +: 8];
            if (wr_decim && s_axi_wstrb[0]) decim_n[7:0]  <= s_axi_wdata[7:0];
            if (wr_decim && s_axi_wstrb[1]) decim_n[15:8] <= s_axi_wdata[15:8];
        end
    end

    // Lowest pending channel is pushed first, giving ascending order
    always_comb begin
        scan_ch     = '0;
        scan_sample = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pend[c]) begin
                scan_ch     = 3'(c);
                scan_sample = 16'(snapshot[c]);
            end
        end
    end

    assign pend_next = pend & (pend - NUM_CH'(1));
    assign push      = (state == ST_SCAN) && !soft_clr;
    assign push_data = {scan_ch, scan_sample};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            pend      <= '0;
            snapshot  <= '0;
            ch_last   <= '0;
            decim_cnt <= '0;
        end else begin
            if (adc_valid) ch_last <= adc_data;
            if (soft_clr) begin
                state     <= ST_IDLE;
                pend      <= '0;
                decim_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (adc_valid) begin
                        if (decim_cnt == decim_n) begin
                            decim_cnt <= '0;
                            snapshot  <= adc_data;
                            if (|mask) begin
                                pend  <= mask;
                                state <= ST_SCAN;
                            end
                        end else begin
                            decim_cnt <= decim_cnt + 16'd1;
                        end
                    end
                    ST_SCAN: begin
                        pend <= pend_next;
                        if (pend_next == '0) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
                if (wr_decim) decim_cnt <= '0;
            end
        end
    end

    assign pop_req  = rd_en && hit(s_axi_araddr, REG_FIFO);
    assign pop_fire = pop_req && !empty && !soft_clr;

    // A new loss event wins over a same-cycle W1C so it is never missed
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            overflow <= 1'b0;
            overrun  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq <= 32'(level) >= 32'(thresh);
            if (soft_clr) begin
                overflow <= 1'b0;
                overrun  <= 1'b0;
            end else begin
                if (push && full && !pop_fire)                        overflow <= 1'b1;
                else if (wr_status && s_axi_wdata[STAT_OVF_BIT])      overflow <= 1'b0;
                if (adc_valid && state == ST_SCAN)                    overrun  <= 1'b1;
                else if (wr_status && s_axi_wdata[STAT_OVR_BIT])      overrun  <= 1'b0;
            end
        end
    end

    axil_adc_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .clear     (soft_clr),
        .push      (push),
        .push_data (push_data),
        .pop       (pop_req),
        .pop_data  (pop_data),
        .level     (level),
        .empty     (empty),
        .full      (full)
    );

    always_comb begin
        rd_word = '0;
        if (hit(s_axi_araddr, REG_CTRL)) begin
            rd_word[CTRL_MASK_LSB +: NUM_CH] = mask;
            rd_word[CTRL_THRESH_LSB +: 8]    = thresh;
        end else if (hit(s_axi_araddr, REG_DECIM)) begin
            rd_word[15:0] = decim_n;
        end else if (hit(s_axi_araddr, REG_STATUS)) begin
            rd_word[STAT_LEVEL_LSB +: 9] = 9'(level);
            rd_word[STAT_EMPTY_BIT]      = empty;
            rd_word[STAT_FULL_BIT]       = full;
            rd_word[STAT_OVF_BIT]        = overflow;
            rd_word[STAT_OVR_BIT]        = overrun;
        end else if (hit(s_axi_araddr, REG_FIFO)) begin
            if (!empty) begin
                rd_word[FD_VALID_BIT]    = 1'b1;
                rd_word[FD_CH_LSB +: 3]  = pop_data.channel;
                rd_word[15:0]            = pop_data.sample;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hit(s_axi_araddr, REG_CH_LAST + 4 * c)) rd_word = 32'(ch_last[c]);
            end
        end
    end
endmodule

// File: tb/tb_axil_adc_capture.sv
// Bench for axil_adc_capture: register-read tables, hand-timed corner
// sequences and randomized captures checked against a queue model.
module tb_axil_adc_capture;
    localparam int NUM_CH = 4, ADC_WIDTH = 14, FIFO_DEPTH = 16, ADDR_WIDTH = 6;
    localparam logic [5:0] A_CTRL = 6'h00, A_DECIM = 6'h04, A_STAT = 6'h08, A_FIFO = 6'h0C;

    typedef logic [NUM_CH-1:0][ADC_WIDTH-1:0] adc_vec_t;
    typedef struct { logic [5:0] addr; logic [31:0] exp; } rd_vec_t;

    logic ACLK = 0, ARESET = 1;
    logic [5:0]  s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [2:0]  s_axi_awprot = '0, s_axi_arprot = '0;
    logic        s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0;
    logic        s_axi_arvalid = 0, s_axi_rready = 0;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    adc_vec_t    adc_data = '0;
    logic        adc_valid = 0;
    logic        irq;

    int vectors = 0, miscompares = 0;

    axil_adc_capture #(.NUM_CH(NUM_CH), .ADC_WIDTH(ADC_WIDTH),
                       .FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .adc_data(adc_data), .adc_valid(adc_valid), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got no handshake, want one within 50 cycles", name);
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge ACLK);
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        n = 0;
        while (!s_axi_awready && n < 50) begin @(negedge ACLK); n++; end
        if (!s_axi_awready) timeout("awready");
        @(posedge ACLK); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 1;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin @(negedge ACLK); n++; end
        if (!s_axi_bvalid) timeout("bvalid");
        else check("bresp", 32'(s_axi_bresp), 32'h0);
        @(posedge ACLK); #1;
        s_axi_bready = 0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        int n;
        @(negedge ACLK);
        s_axi_araddr = a; s_axi_arvalid = 1;
        n = 0;
        while (!s_axi_arready && n < 50) begin @(negedge ACLK); n++; end
        if (!s_axi_arready) timeout("arready");
        @(posedge ACLK); #1;
        s_axi_arvalid = 0; s_axi_rready = 1;
        n = 0;
        while (!s_axi_rvalid && n < 50) begin @(negedge ACLK); n++; end
        if (!s_axi_rvalid) timeout("rvalid");
        d = s_axi_rdata;
        @(posedge ACLK); #1;
        s_axi_rready = 0;
    endtask

    task automatic read_check(input string name, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, d);
        check(name, d, exp);
    endtask

    // Strobe is sampled on the posedge after it is driven; the next strobe
    // is sampled gap+2 cycles later
    task automatic strobe(input adc_vec_t d, input int gap);
        @(negedge ACLK);
        adc_data = d; adc_valid = 1;
        @(negedge ACLK);
        adc_valid = 0;
        repeat (gap) @(negedge ACLK);
    endtask

    function automatic adc_vec_t chans(input int a, input int b, input int c, input int e);
        adc_vec_t v;
        v[0] = 14'(a); v[1] = 14'(b); v[2] = 14'(c); v[3] = 14'(e);
        return v;
    endfunction

    rd_vec_t tbl[$];
    logic [31:0] d, dfork;
    adc_vec_t dv;
    logic [31:0] q[$];
    int m, n, th, ns, pc, ch;
    logic ovf;
    logic [31:0] exp_stat;

    initial begin
        // ---------------- reset ----------------
        @(negedge ACLK);
        check("irq_in_reset", 32'(irq), 32'h0);
        repeat (2) @(negedge ACLK);
        ARESET = 0;
        repeat (2) @(negedge ACLK);
        check("irq_thresh0_after_reset", 32'(irq), 32'h1);

        tbl = '{'{6'h00, 32'h0}, '{6'h04, 32'h0}, '{6'h08, 32'h0001_0000},
                '{6'h0C, 32'h0}, '{6'h10, 32'h0}, '{6'h14, 32'h0}, '{6'h18, 32'h0},
                '{6'h1C, 32'h0}, '{6'h20, 32'h0}, '{6'h3C, 32'h0}};
        for (int i = 0; i < tbl.size(); i++)
            read_check($sformatf("reset_rd_%h", tbl[i].addr), tbl[i].addr, tbl[i].exp);

        // ---------------- byte strobes, unmapped write ----------------
        axi_write(A_CTRL, 32'hFFFF_FFFF, 4'b0001);
        read_check("ctrl_wstrb_lane0", A_CTRL, 32'h0000_000F);
        axi_write(A_DECIM, 32'h0000_ABCD, 4'b0010);
        read_check("decim_wstrb_lane1", A_DECIM, 32'h0000_AB00);
        axi_write(6'h30, 32'hFFFF_FFFF, 4'b1111);
        read_check("unmapped_write_ignored", A_CTRL, 32'h0000_000F);

        // ---------------- mask ch0+ch2 single capture ----------------
        axi_write(A_DECIM, 32'h0, 4'hF);
        axi_write(A_CTRL, 32'h0000_0005, 4'hF);
        strobe(chans('h11, 'h22, 'h33, 'h44), 3);
        tbl = '{'{A_FIFO, 32'h8000_0011}, '{A_FIFO, 32'h8200_0033}, '{A_FIFO, 32'h0},
                '{6'h1C, 32'h44}, '{6'h10, 32'h11}, '{A_STAT, 32'h0001_0000}};
        for (int i = 0; i < tbl.size(); i++)
            read_check($sformatf("mask5_rd%0d_%h", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);

        // ---------------- decimation by 3 ----------------
        axi_write(A_DECIM, 32'h2, 4'hF);
        axi_write(A_CTRL, 32'h8000_0001, 4'hF);
        for (int i = 1; i <= 9; i++) strobe(chans(i, 0, 0, 0), 2);
        read_check("decim_status", A_STAT, 32'h0000_0003);
        read_check("decim_pop1", A_FIFO, 32'h8000_0003);
        read_check("decim_pop2", A_FIFO, 32'h8000_0006);
        read_check("decim_pop3", A_FIFO, 32'h8000_0009);

        // ---------------- overrun ----------------
        axi_write(A_DECIM, 32'h0, 4'hF);
        axi_write(A_CTRL, 32'h8000_000F, 4'hF);
        strobe(chans(1, 2, 3, 4), 0);
        strobe(chans(5, 6, 7, 8), 4);
        read_check("overrun_status", A_STAT, 32'h0008_0004);
        axi_write(A_STAT, 32'h0008_0000, 4'hF);
        read_check("overrun_w1c", A_STAT, 32'h0000_0004);
        read_check("overrun_first_entry", A_FIFO, 32'h8000_0001);

        // ---------------- overflow and soft clear ----------------
        axi_write(A_CTRL, 32'h8000_0001, 4'hF);
        for (int i = 0; i < 17; i++) strobe(chans(i, 0, 0, 0), 0);
        read_check("overflow_status", A_STAT, 32'h0006_0010);
        axi_write(A_CTRL, 32'h8000_0001, 4'hF);
        read_check("soft_clear_status", A_STAT, 32'h0001_0000);
        read_check("soft_clear_ctrl", A_CTRL, 32'h0000_0001);

        // ---------------- irq threshold, push+pop while full ----------------
        axi_write(A_CTRL, 32'h8004_0001, 4'hF);
        for (int i = 1; i <= 3; i++) strobe(chans('h100 + i, 0, 0, 0), 0);
        repeat (3) @(negedge ACLK);
        check("irq_low_level3", 32'(irq), 32'h0);
        strobe(chans('h104, 0, 0, 0), 0);
        @(posedge ACLK);
        @(posedge ACLK);
        @(negedge ACLK);
        check("irq_high_after_4th_push", 32'(irq), 32'h1);
        read_check("irq_pop", A_FIFO, 32'h8000_0101);
        check("irq_low_after_pop", 32'(irq), 32'h0);
        for (int i = 5; i <= 17; i++) strobe(chans('h100 + i, 0, 0, 0), 0);
        read_check("full_before_pushpop", A_STAT, 32'h0002_0010);
        fork
            axi_read(A_FIFO, dfork);
            strobe(chans('h118, 0, 0, 0), 0);
        join
        check("pushpop_full_data", dfork, 32'h8000_0102);
        repeat (2) @(negedge ACLK);
        read_check("pushpop_full_status", A_STAT, 32'h0002_0010);

        // ---------------- randomized captures vs queue model ----------------
        for (int it = 0; it < 10; it++) begin
            m  = $urandom_range(0, 15);
            n  = $urandom_range(0, 3);
            th = $urandom_range(0, 20);
            ns = $urandom_range(1, 10);
            pc = $countones(m);
            axi_write(A_DECIM, 32'(n), 4'hF);
            axi_write(A_CTRL, 32'h8000_0000 | (32'(th) << 16) | 32'(m), 4'hF);
            q.delete();
            ovf = 0;
            for (int s = 0; s < ns; s++) begin
                for (int c = 0; c < NUM_CH; c++) dv[c] = 14'($urandom_range(0, 16383));
                strobe(dv, pc + $urandom_range(0, 2));
                if ((s + 1) % (n + 1) == 0) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (m[c]) begin
                            if (q.size() < FIFO_DEPTH) q.push_back(32'h8000_0000 | (32'(c) << 24) | 32'(dv[c]));
                            else ovf = 1;
                        end
                    end
                end
            end
            repeat (4) @(negedge ACLK);
            exp_stat = (32'(ovf) << 18) | (32'(q.size() == FIFO_DEPTH) << 17) |
                       (32'(q.size() == 0) << 16) | 32'(q.size());
            read_check($sformatf("rand%0d_status", it), A_STAT, exp_stat);
            check($sformatf("rand%0d_irq", it), 32'(irq), 32'(q.size() >= th));
            ch = $urandom_range(0, NUM_CH - 1);
            read_check($sformatf("rand%0d_ch_last%0d", it, ch), 6'(16 + 4 * ch), 32'(dv[ch]));
            while (q.size() > 0) read_check($sformatf("rand%0d_pop", it), A_FIFO, q.pop_front());
            read_check($sformatf("rand%0d_empty_pop", it), A_FIFO, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
